// File: rtl/decode_stage.sv
// MIPS ID stage: register file with write-back bypass, immediate extension,
// load-use hazard detection and the ID/EX pipeline register.
module decode_stage #(
    parameter int NBITS = 32,
    parameter int NREGS = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [31:0]       i_instruction,
    input  logic [NBITS-1:0]  i_pc_plus4,
    input  logic              i_valid,
    input  logic              i_flush,
    input  logic              i_wb_write,
    input  logic [4:0]        i_wb_addr,
    input  logic [NBITS-1:0]  i_wb_data,
    output logic              o_stall,
    output logic              o_valid,
    output logic [NBITS-1:0]  o_rs_data,
    output logic [NBITS-1:0]  o_rt_data,
    output logic [NBITS-1:0]  o_imm,
    output logic [4:0]        o_rs,
    output logic [4:0]        o_rt,
    output logic [4:0]        o_rd,
    output logic [4:0]        o_shamt,
    output logic [5:0]        o_opcode,
    output logic [5:0]        o_funct,
    output logic [NBITS-1:0]  o_pc_plus4,
    output logic              o_mem_read,
    output logic              o_reg_write
);

    typedef struct packed {
        logic              valid;
        logic              mem_read;
        logic              reg_write;
        logic [5:0]        opcode;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [4:0]        shamt;
        logic [5:0]        funct;
        logic [NBITS-1:0]  rs_data;
        logic [NBITS-1:0]  rt_data;
        logic [NBITS-1:0]  imm;
        logic [NBITS-1:0]  pc_plus4;
    } idex_t;

    logic [NBITS-1:0] rf_q [NREGS];
    idex_t            idex_q;
    idex_t            idex_d;

    logic [5:0]       opcode_s;
    logic [4:0]       rs_s;
    logic [4:0]       rt_s;
    logic [5:0]       funct_s;
    logic [NBITS-1:0] rs_data_s;
    logic [NBITS-1:0] rt_data_s;
    logic [NBITS-1:0] imm_s;
    logic             mem_read_s;
    logic             reg_write_s;
    logic             uses_rt_s;
    logic             stall_s;

    assign opcode_s = i_instruction[31:26];
    assign rs_s     = i_instruction[25:21];
    assign rt_s     = i_instruction[20:16];
    assign funct_s  = i_instruction[5:0];

    // LUI places the immediate in the upper half; logical ops zero-extend.
    function automatic logic [NBITS-1:0] extend_imm(input logic [5:0] op, input logic [15:0] imm);
        logic [NBITS-1:0] r;
        case (op)
            6'b001111: r = NBITS'({imm, 16'h0000});
            6'b001100,
            6'b001101,
            6'b001110: r = {{(NBITS-16){1'b0}}, imm};
            default:   r = {{(NBITS-16){imm[15]}}, imm};
        endcase
        return r;
    endfunction

    // Register file storage: cleared by reset, r0 never written.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < NREGS; k++) begin
                rf_q[k] <= '0;
            end
        end else if (i_wb_write && (i_wb_addr != 5'd0)) begin
            rf_q[i_wb_addr] <= i_wb_data;
        end
    end

    // Operand read with same-cycle write-back bypass.
    always_comb begin
        rs_data_s = '0;
        rt_data_s = '0;
        if (rs_s == 5'd0) begin
            rs_data_s = '0;
        end else if (i_wb_write && (i_wb_addr == rs_s)) begin
            rs_data_s = i_wb_data;
        end else begin
            rs_data_s = rf_q[rs_s];
        end
        if (rt_s == 5'd0) begin
            rt_data_s = '0;
        end else if (i_wb_write && (i_wb_addr == rt_s)) begin
            rt_data_s = i_wb_data;
        end else begin
            rt_data_s = rf_q[rt_s];
        end
    end

    assign imm_s       = extend_imm(opcode_s, i_instruction[15:0]);
    assign mem_read_s  = (opcode_s[5:3] == 3'b100);
    assign reg_write_s = ((opcode_s == 6'b000000) && (funct_s != 6'b001000))
                       || (opcode_s[5:3] == 3'b001)
                       || (opcode_s[5:3] == 3'b100)
                       || (opcode_s == 6'b000011);
    assign uses_rt_s   = (opcode_s == 6'b000000) || (opcode_s == 6'b000100)
                       || (opcode_s == 6'b000101) || (opcode_s[5:3] == 3'b101);

    // Load-use hazard against the load currently in ID/EX; a flush overrides it.
    always_comb begin
        stall_s = 1'b0;
        if (i_flush) begin
            stall_s = 1'b0;
        end else begin
            stall_s = idex_q.valid && idex_q.mem_read && (idex_q.rt != 5'd0) && i_valid
                   && ((idex_q.rt == rs_s) || (uses_rt_s && (idex_q.rt == rt_s)));
        end
    end

    // Next ID/EX contents: bubble on flush, stall or empty IF/ID.
    always_comb begin
        idex_d = '0;
        if (i_flush || stall_s || !i_valid) begin
            idex_d = '0;
        end else begin
            idex_d.valid     = 1'b1;
            idex_d.mem_read  = mem_read_s;
            idex_d.reg_write = reg_write_s;
            idex_d.opcode    = opcode_s;
            idex_d.rs        = rs_s;
            idex_d.rt        = rt_s;
            idex_d.rd        = i_instruction[15:11];
            idex_d.shamt     = i_instruction[10:6];
            idex_d.funct     = funct_s;
            idex_d.rs_data   = rs_data_s;
            idex_d.rt_data   = rt_data_s;
            idex_d.imm       = imm_s;
            idex_d.pc_plus4  = i_pc_plus4;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign o_stall     = stall_s;
    assign o_valid     = idex_q.valid;
    assign o_mem_read  = idex_q.mem_read;
    assign o_reg_write = idex_q.reg_write;
    assign o_opcode    = idex_q.opcode;
    assign o_rs        = idex_q.rs;
    assign o_rt        = idex_q.rt;
    assign o_rd        = idex_q.rd;
    assign o_shamt     = idex_q.shamt;
    assign o_funct     = idex_q.funct;
    assign o_rs_data   = idex_q.rs_data;
    assign o_rt_data   = idex_q.rt_data;
    assign o_imm       = idex_q.imm;
    assign o_pc_plus4  = idex_q.pc_plus4;

endmodule
